// File: rtl/ledr_pattern_sequencer.sv
// Avalon-MM red-LED controller: manual pass-through in IDLE, or a rotate/bounce
// pattern engine that steps at a programmable interval for a programmable count.
module ledr_pattern_sequencer #(
  parameter int WIDTH    = 18,
  parameter int PERIOD_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    data_q, seed_q, pattern_q, pattern_d, pat_adv, out_d;
  logic [PERIOD_W-1:0] period_q, tick_q, tick_d, reload;
  logic [15:0]         steps_q, step_cnt_q, step_cnt_d, step_inc;
  logic                run_q, mode_q, irq_en_q, done_q;
  logic                dir_q, dir_d, dir_adv;
  logic                wr_en, wr_ctrl, start, stop, set_done, clr_done;
  logic                unused_wd;

  assign wr_en    = chipselect & ~write_n;
  assign wr_ctrl  = wr_en && (address == 3'd1);
  assign start    = wr_ctrl & writedata[0];
  assign stop     = wr_ctrl & ~writedata[0];
  assign clr_done = wr_en && (address == 3'd5) && writedata[1];
  assign unused_wd = ^writedata;

  // A zero PERIOD behaves as one clock per step.
  assign reload   = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
  assign step_inc = step_cnt_q + 16'd1;

  always_comb begin
    pat_adv = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
    dir_adv = dir_q;
    if (mode_q) begin
      if (!dir_q) begin
        if (pattern_q[WIDTH-1]) begin
          dir_adv = 1'b1;
          pat_adv = pattern_q >> 1;
        end else begin
          pat_adv = pattern_q << 1;
        end
      end else begin
        if (pattern_q[0]) begin
          dir_adv = 1'b0;
          pat_adv = pattern_q << 1;
        end else begin
          pat_adv = pattern_q >> 1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    dir_d      = dir_q;
    tick_d     = tick_q;
    step_cnt_d = step_cnt_q;
    set_done   = 1'b0;
    if (start) begin
      // Start and restart share the same full reload from any state.
      state_d    = RUN;
      pattern_d  = seed_q;
      dir_d      = 1'b0;
      tick_d     = reload;
      step_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (tick_q == '0) begin
            pattern_d  = pat_adv;
            dir_d      = dir_adv;
            tick_d     = reload;
            step_cnt_d = step_inc;
            if (steps_q != 16'd0 && step_inc == steps_q) begin
              state_d  = HOLD;
              set_done = 1'b1;
            end
          end else begin
            tick_d = tick_q - PERIOD_W'(1);
          end
        end
        HOLD: if (stop) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    out_d = (state_d == IDLE) ? data_q : pattern_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      seed_q     <= '0;
      period_q   <= '0;
      steps_q    <= '0;
      run_q      <= 1'b0;
      mode_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      pattern_q  <= '0;
      dir_q      <= 1'b0;
      tick_q     <= '0;
      step_cnt_q <= '0;
      out_port   <= '0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      dir_q      <= dir_d;
      tick_q     <= tick_d;
      step_cnt_q <= step_cnt_d;
      out_port   <= out_d;
      if (wr_en) begin
        case (address)
          3'd0: data_q   <= writedata[WIDTH-1:0];
          3'd2: period_q <= writedata[PERIOD_W-1:0];
          3'd3: seed_q   <= writedata[WIDTH-1:0];
          3'd4: steps_q  <= writedata[15:0];
          default: ;
        endcase
      end
      if (wr_ctrl) begin
        run_q    <= writedata[0];
        mode_q   <= writedata[1];
        irq_en_q <= writedata[2];
      end else if (set_done) begin
        run_q <= 1'b0;
      end
      // Completion beats a simultaneous W1C.
      if (set_done)      done_q <= 1'b1;
      else if (clr_done) done_q <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata[WIDTH-1:0]    = data_q;
      3'd1: readdata[2:0]          = {irq_en_q, mode_q, run_q};
      3'd2: readdata[PERIOD_W-1:0] = period_q;
      3'd3: readdata[WIDTH-1:0]    = seed_q;
      3'd4: readdata[15:0]         = steps_q;
      3'd5: readdata = {step_cnt_q, 13'd0, dir_q, done_q, state_q == RUN};
      default: readdata = '0;
    endcase
  end

  assign irq = done_q & irq_en_q;

endmodule

// File: tb/tb_ledr_pattern_sequencer.sv
// Scoreboard bench: stimulus queues expectations tagged with a due cycle, a
// negedge monitor pops and compares them against the DUT.
module tb_ledr_pattern_sequencer;
  localparam int WIDTH = 18;
  localparam int K_OUT = 0, K_IRQ = 1, K_RD = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;
  logic             irq;

  typedef struct {
    int          kind;
    int          due;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  ledr_pattern_sequencer #(.WIDTH(WIDTH), .PERIOD_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          K_OUT:   act = {{(32-WIDTH){1'b0}}, out_port};
          K_IRQ:   act = {31'd0, irq};
          default: act = readdata;
        endcase
        n_checks++;
        if (sb[i].due < cyc) begin
          n_fail++;
          $display("FAIL %s: missed due cycle %0d (now %0d)", sb[i].name, sb[i].due, cyc);
        end else if (act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s: got %h want %h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step_clk();
  endtask

  task automatic exp_at(input int kind, input int dly, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = kind; e.due = cyc + dly; e.exp = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] v, input string nm);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    exp_at(K_RD, 0, v, nm);
    step_clk();
  endtask

  initial begin
    step_clk(); step_clk();
    reset_n = 1'b1;
    step_clk();

    // Reset state
    exp_at(K_OUT, 0, 32'h0, "rst_out");
    exp_at(K_IRQ, 0, 32'h0, "rst_irq");
    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("rst_rd%0d", a));

    // Manual DATA pass-through, one-cycle latency
    wr(3'd0, 32'h2AAAA);
    exp_at(K_OUT, 0, 32'h0, "data_lat0");
    exp_at(K_OUT, 1, 32'h2AAAA, "data_lat1");
    rd(3'd0, 32'h0002AAAA, "data_rd");
    wr(3'd6, 32'hFFFFFFFF);
    rd(3'd6, 32'h0, "addr6_rd");

    // Rotate, PERIOD=3, STEPS=2, irq enabled
    wr(3'd3, 32'h20000); wr(3'd2, 32'd3); wr(3'd4, 32'd2); wr(3'd1, 32'h5);
    exp_at(K_OUT, 0, 32'h20000, "rot_seed");
    exp_at(K_OUT, 2, 32'h20000, "rot_pre1");
    exp_at(K_OUT, 3, 32'h00001, "rot_s1");
    exp_at(K_OUT, 5, 32'h00001, "rot_pre2");
    exp_at(K_OUT, 6, 32'h00002, "rot_s2");
    repeat (7) step_clk();
    exp_at(K_OUT, 0, 32'h00002, "rot_hold");
    exp_at(K_IRQ, 0, 32'h1, "rot_irq");
    rd(3'd5, 32'h00020002, "rot_status");
    rd(3'd1, 32'h4, "rot_ctrl");
    wr(3'd5, 32'h2);
    exp_at(K_IRQ, 0, 32'h0, "rot_irq_clr");
    rd(3'd5, 32'h00020000, "rot_status_clr");

    // Bounce, PERIOD=0 (every clock), STEPS=40
    wr(3'd4, 32'd40); wr(3'd2, 32'd0); wr(3'd3, 32'h1); wr(3'd1, 32'h3);
    exp_at(K_OUT, 0, 32'h00001, "bnc_seed");
    exp_at(K_OUT, 17, 32'h20000, "bnc_s17");
    exp_at(K_OUT, 18, 32'h10000, "bnc_s18");
    exp_at(K_OUT, 34, 32'h00001, "bnc_s34");
    exp_at(K_OUT, 35, 32'h00002, "bnc_s35");
    exp_at(K_OUT, 40, 32'h00040, "bnc_s40");
    exp_at(K_OUT, 41, 32'h00040, "bnc_hold");
    repeat (18) step_clk();
    rd(3'd5, 32'h00120005, "bnc_status18");
    repeat (21) step_clk();
    exp_at(K_IRQ, 0, 32'h0, "bnc_irq_off");
    rd(3'd5, 32'h00280002, "bnc_status40");
    rd(3'd1, 32'h2, "bnc_ctrl");

    // Collision: W1C on the completing edge
    wr(3'd5, 32'h2);
    rd(3'd5, 32'h00280000, "col_pre_status");
    wr(3'd4, 32'd1); wr(3'd2, 32'd2); wr(3'd1, 32'h5);
    exp_at(K_OUT, 0, 32'h00001, "col_seed");
    step_clk();
    wr(3'd5, 32'h2);
    exp_at(K_IRQ, 0, 32'h1, "col_irq");
    exp_at(K_OUT, 0, 32'h00002, "col_out");
    rd(3'd5, 32'h00010002, "col_status");

    // Async reset mid-RUN with irq asserted
    wr(3'd1, 32'h5);
    exp_at(K_IRQ, 0, 32'h1, "arst_pre_irq");
    exp_at(K_OUT, 0, 32'h00001, "arst_pre_out");
    step_clk();
    reset_n = 1'b0;
    #1;
    exp_at(K_OUT, 0, 32'h0, "arst_out");
    exp_at(K_IRQ, 0, 32'h0, "arst_irq");
    rd(3'd5, 32'h0, "arst_status");
    rd(3'd3, 32'h0, "arst_seed");
    reset_n = 1'b1;
    step_clk();

    // Abort mid-interval, STEPS=0
    wr(3'd0, 32'h155); wr(3'd3, 32'h3); wr(3'd2, 32'd5); wr(3'd1, 32'h1);
    exp_at(K_OUT, 0, 32'h00003, "abt_seed");
    step_clk(); step_clk();
    wr(3'd1, 32'h0);
    exp_at(K_OUT, 0, 32'h00155, "abt_out");
    exp_at(K_IRQ, 0, 32'h0, "abt_irq");
    rd(3'd5, 32'h0, "abt_status");

    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ledr_pattern_sequencer.md
Name: ledr_pattern_sequencer

Overview:
Avalon-MM slave controller that owns the red-LED output bank and sequences it. In manual mode the CPU value is driven straight through, matching a plain output PIO. In run mode a hardware engine steps a seed pattern (rotate or bounce) at a programmable interval for a programmable step count. On completion it raises a sticky done flag and an optional interrupt.

Parameters:
WIDTH, 18, LED bank width (2..32)
PERIOD_W, 24, width of step-interval register/counter (1..32)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational from address, zero-extended
out_port  out  WIDTH  LED drive, registered
irq  out  1  interrupt, level, = done & irq_en

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All registers 0, state IDLE, out_port 0, irq 0, readdata follows address (reads 0 except address-decoded zeros).
- Write accepted when chipselect & ~write_n; effective at that clk edge.
- Register map (word addresses):
  - 0 DATA[WIDTH-1:0]: manual value.
  - 1 CTRL: bit0 run, bit1 mode (0 rotate-left, 1 bounce), bit2 irq_en.
  - 2 PERIOD[PERIOD_W-1:0]: clocks per step; 0 treated as 1.
  - 3 SEED[WIDTH-1:0]: pattern loaded at start.
  - 4 STEPS[15:0]: steps before completion; 0 = run forever.
  - 5 STATUS (read): bit0 busy (state==RUN), bit1 done, bit2 dir (0 left, 1 right), [31:16] step_count. Writing 1 to bit1 clears done; other bits are read-only.
  - 6,7: read 0, writes ignored.
- States IDLE, RUN, HOLD.
- IDLE: out_port <= DATA each cycle (one-cycle latency from a DATA write).
  - CTRL write with run=1 -> RUN: pattern<=SEED, dir<=left, tick<=max(PERIOD,1)-1, step_count<=0.
  - out_port shows SEED from the cycle after that write.
- RUN: tick decrements each clk. At tick==0:
  - Advance pattern; reload tick from the current PERIOD register; step_count+1.
  - If STEPS!=0 and step_count+1==STEPS: -> HOLD, done<=1, CTRL.run<=0.
  - Result: first step lands exactly max(PERIOD,1) clocks after the start edge.
  - CTRL write with run=0 -> IDLE immediately; out_port returns to DATA next cycle.
  - CTRL write with run=1 while in RUN restarts, with full reload as from IDLE.
  - Writes to PERIOD/SEED/STEPS/DATA during RUN are stored. PERIOD applies at the next reload; SEED/STEPS apply at the next start; DATA is displayed only in IDLE.
- HOLD: out_port holds the final pattern.
  - CTRL write with run=0 -> IDLE.
  - CTRL write with run=1 -> restart (RUN, reload).
- Rotate mode: pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]}.
- Bounce mode: zero-fill logical shifts.
  - dir=left and pattern[WIDTH-1]=1: dir<=right, pattern<=pattern>>1.
  - dir=left otherwise: pattern<=pattern<<1.
  - dir=right and pattern[0]=1: dir<=left, pattern<=pattern<<1.
  - dir=right otherwise: pattern<=pattern>>1.
- Degenerate patterns: seed 0 stays 0. All-ones in rotate mode stays all-ones. Both are legal, no special case.
- step_count is 16-bit and wraps silently when STEPS=0.
- done: set on entry to HOLD. If a set and a W1C clear occur in the same cycle, set wins. irq is combinational from the done and irq_en flops.
- Reset asserted mid-RUN: immediate return to reset values. No completion, no irq.

Test Plan:
- Reset, then read all addresses -> readdata 0. out_port 0, irq 0.
- Write DATA=0x2AAAA in IDLE -> out_port=0x2AAAA one cycle later. Read addr0 -> 0x0002AAAA.
- Rotate: SEED=0x20000, PERIOD=3, STEPS=2, CTRL=0x5.
  - out_port=0x20000 next cycle, 0x00001 3 clocks after start, 0x00002 6 clocks after start.
  - Then HOLD: STATUS=0x00020002, irq=1.
  - W1C STATUS bit1 -> irq=0.
- Bounce: SEED=0x00001, PERIOD=0, STEPS=40, CTRL=0x3.
  - Steps every clock. out_port reaches 0x20000 at step 17 and 0x10000 at step 18 with dir=1.
  - Returns to 0x00001 at step 34, final 0x00040 at step 40.
- Abort: in RUN with STEPS=0, write CTRL=0 mid-interval.
  - Next cycle out_port=DATA, busy=0, done=0.
  - Assert reset_n low mid-RUN -> all outputs 0 asynchronously.
- Collision: W1C done on the same edge that a run completes -> done remains 1, irq=1 when irq_en set.
